uart_tx_framer: RTL
===================

# uart_tx_framer

Parametrised UART transmitter with a valid/ready byte handshake, configurable frame format (data bits, parity, stop bits) and an optional ASCII offset. Bit rate is derived from the system clock frequency at elaboration time. It replaces the free-running fixed-frame transmitter: a frame is sent only when a word is offered and accepted. It sits between a byte-producing client and the board TX pin.

## Interface
- F, 50000000, system clock frequency in Hz
- BAUD, 115200, bit rate; bit period DIV = F/BAUD clocks (integer division; 434 at defaults); elaboration error if DIV < 2
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- ASCII_OFS, 0, constant added to data at capture, modulo 2^DATA_BITS (48 turns digits 0..9 into '0'..'9')

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- data  in  DATA_BITS  word to send
- valid  in  1  data is offered
- ready  out  1  block can accept a word (high only in IDLE)
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress (high in any state other than IDLE)

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: tx=1, ready=1. On valid&&ready at a clock edge:
  - capture (data+ASCII_OFS) mod 2^DATA_BITS into the shift register
  - compute the parity bit from the captured value
  - clear the baud counter and bit index
  - go to START
- START: tx=0 for DIV clocks, then DATA.
- DATA: tx = shift register LSB first, DATA_BITS bits of DIV clocks each. Then PAR if PARITY≠0, else STOP.
- PAR: one bit of DIV clocks.
  - Even parity: bit = XOR of the data bits.
  - Odd parity: bit = inverted XOR.
  - Parity is computed over the offset-adjusted value.
- STOP: tx=1 for STOP_BITS×DIV clocks, then IDLE.
- Baud counter counts 0..DIV-1. Width is ceil(log2(DIV)). Wraps to 0 at each bit boundary.
- Bit index width is ceil(log2(DATA_BITS+1)).
- data and valid are ignored outside IDLE. Changing data mid-frame has no effect on tx.

## Timing
- Reset (rst low, asynchronous): state IDLE, tx=1, busy=0, ready=1, counters 0. Takes effect immediately.
- Reset mid-frame abandons the frame. tx returns high immediately, with no resumption. After reset, the first word is accepted at the first clock edge where rst=1 and valid=1.
- Frame length N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Acceptance at edge k:
  - tx falls and busy rises on edge k.
  - Bit b (0 = start) occupies edges k+b×DIV through k+(b+1)×DIV−1.
- The state returns to IDLE at edge k+N×DIV. ready rises and busy falls on that edge.
- With valid held high, the next acceptance is at edge k+N×DIV+1. Minimum frame-to-frame spacing is N×DIV+1 clocks, so the last stop bit is effectively stretched by one clock.
- No combinational path from valid or data to tx. ready and busy are decoded from the state register.

## Test plan
- Defaults, data=0x55, one valid pulse:
  - tx low for 434 clocks, then 1,0,1,0,1,0,1,0 at 434 clocks each
  - then high 434 clocks
  - ready is low for exactly 4340 clocks
- PARITY=2, data=0x07:
  - data bits 1,1,1,0,0,0,0,0
  - parity bit 1
  - N=11
- PARITY=1, STOP_BITS=2, DATA_BITS=7, data=0x00:
  - parity bit 1
  - stop high for 2×DIV clocks
  - N=11
- ASCII_OFS=48, data=3: transmitted byte is 0x33.
- valid held high with data=0xA5 then 0x3C:
  - second start edge exactly N×DIV+1 clocks after the first
  - data changed mid-frame does not alter the first frame
- rst pulled low in the middle of the DATA bits:
  - tx=1, ready=1, busy=0 immediately
  - after release, a new word produces a full, correct frame

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmitter with valid/ready byte intake and elaboration-time frame format.
// The bit period is F/BAUD clocks. Optional parity, 1-2 stop bits, ASCII offset added at capture.
module uart_tx_framer #(
  parameter int unsigned F         = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned ASCII_OFS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned DIV   = F / BAUD;
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]     DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]     STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [DATA_BITS-1:0] OFS       = DATA_BITS'(ASCII_OFS);
  localparam logic                 PAR_ODD   = (PARITY == 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_framer: F/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_framer: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] cap;
  logic                 bit_end;

  // Next-state and datapath; tx_d is the line level for the next clock period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    cap     = data + OFS;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (valid) begin
          shift_d = cap;
          par_d   = (^cap) ^ PAR_ODD;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx    = tx_q;
  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);

endmodule
